sim_exit_monitor: RTL and testbench

- Downstream consumer of the simulation top's extracted `wfi` flag and `a0` register value.
- Decides when firmware has finished a test and whether it passed, failed or hung.
- Produces sticky done/pass/fail/timeout status plus cycle and WFI statistics.
- The C++ harness polls these outputs to end the run and set the process exit code.

---
 rtl/sim_exit_monitor.sv | 158 +++++++++++++++
 tb/tb_sim_exit_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// Watches the firmware's WFI/a0 handshake and decides when a simulated test is over.
// Reports sticky done/pass/fail/timeout status together with cycle and WFI statistics.
module sim_exit_monitor #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter logic [31:0] PASS_CODE      = 32'h0000_0000,
   parameter int          CYCLE_W        = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               wfi,
   input  logic [31:0]        a0,
   output logic               done,
   output logic               pass,
   output logic               fail,
   output logic               timeout,
   output logic [31:0]        result_code,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic [15:0]        wfi_count
);

   localparam int              SC_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [63:0]     TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [31:0]     cap;
   logic [SC_W-1:0] settle_cnt;
   logic            timeout_hit, a0_match, settle_hit;
   logic            active, abort, fin_to, fin_ok, capture, settle_inc;
   logic [31:0]     fin_val;

   function automatic logic [CYCLE_W-1:0] sat_inc_cycle(input logic [CYCLE_W-1:0] v);
      return (&v) ? v : v + CYCLE_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc_wfi(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (64'(cycle_count) == TO_LAST);
   assign a0_match    = (a0 == cap);
   assign settle_hit  = a0_match && (settle_cnt == SC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Timeout outranks every other exit from RUN/SETTLE, including an abort.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (enable) state_nxt = S_RUN;
         S_RUN: begin
            if (timeout_hit)  state_nxt = S_DONE;
            else if (!enable) state_nxt = S_IDLE;
            else if (wfi)     state_nxt = (SETTLE_CYCLES == 0) ? S_DONE : S_SETTLE;
         end
         S_SETTLE: begin
            if (timeout_hit)     state_nxt = S_DONE;
            else if (!enable)    state_nxt = S_IDLE;
            else if (settle_hit) state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      active     = (state == S_RUN) || (state == S_SETTLE);
      abort      = active && !timeout_hit && !enable;
      fin_to     = active && timeout_hit;
      fin_ok     = 1'b0;
      capture    = 1'b0;
      settle_inc = 1'b0;
      fin_val    = a0;
      case (state)
         S_RUN: begin
            if (!timeout_hit && enable && wfi) begin
               if (SETTLE_CYCLES == 0) fin_ok  = 1'b1;
               else                    capture = 1'b1;
            end
         end
         S_SETTLE: begin
            if (!timeout_hit && enable) begin
               if (!a0_match) begin
                  capture = 1'b1;
               end else if (settle_hit) begin
                  fin_ok  = 1'b1;
                  fin_val = cap;
               end else begin
                  settle_inc = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Status fields are loaded together on the DONE entry edge and never touched again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         result_code <= 32'd0;
         cycle_count <= '0;
         wfi_count   <= 16'd0;
         cap         <= 32'd0;
         settle_cnt  <= '0;
      end else if (abort) begin
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         result_code <= 32'd0;
         cycle_count <= '0;
         wfi_count   <= 16'd0;
         cap         <= 32'd0;
         settle_cnt  <= '0;
      end else begin
         if (active) begin
            cycle_count <= sat_inc_cycle(cycle_count);
            if (wfi) wfi_count <= sat_inc_wfi(wfi_count);
         end
         if (fin_to) begin
            done        <= 1'b1;
            pass        <= 1'b0;
            fail        <= 1'b1;
            timeout     <= 1'b1;
            result_code <= 32'hFFFF_FFFF;
         end else if (fin_ok) begin
            done        <= 1'b1;
            pass        <= (fin_val == PASS_CODE);
            fail        <= (fin_val != PASS_CODE);
            timeout     <= 1'b0;
            result_code <= fin_val;
         end
         if (capture) begin
            cap        <= a0;
            settle_cnt <= '0;
         end else if (settle_inc) begin
            settle_cnt <= settle_cnt + SC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Bench for sim_exit_monitor: three configurations share one input stream and are
// compared every cycle against a rule-level model of the exit protocol.
module tb_sim_exit_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        wfi = 1'b0;
   logic [31:0] a0 = 32'd0;

   logic        done_v [3];
   logic        pass_v [3];
   logic        fail_v [3];
   logic        to_v   [3];
   logic [31:0] res_v  [3];
   logic [15:0] wc_v   [3];
   logic [31:0] cc_v   [3];
   logic [31:0] cc_a, cc_b;
   logic [5:0]  cc_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // A: long timeout, 8-cycle settle. B: 50-cycle timeout. C: no timeout, no settle, 6-bit counter.
   sim_exit_monitor #(.TIMEOUT_CYCLES(32'd5000), .SETTLE_CYCLES(8), .PASS_CODE(32'h0), .CYCLE_W(32)) u_a (
      .clk(clk), .reset(reset), .enable(enable), .wfi(wfi), .a0(a0),
      .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(to_v[0]),
      .result_code(res_v[0]), .cycle_count(cc_a), .wfi_count(wc_v[0]));
   sim_exit_monitor #(.TIMEOUT_CYCLES(32'd50), .SETTLE_CYCLES(8), .PASS_CODE(32'h0), .CYCLE_W(32)) u_b (
      .clk(clk), .reset(reset), .enable(enable), .wfi(wfi), .a0(a0),
      .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(to_v[1]),
      .result_code(res_v[1]), .cycle_count(cc_b), .wfi_count(wc_v[1]));
   sim_exit_monitor #(.TIMEOUT_CYCLES(32'd0), .SETTLE_CYCLES(0), .PASS_CODE(32'h0), .CYCLE_W(6)) u_c (
      .clk(clk), .reset(reset), .enable(enable), .wfi(wfi), .a0(a0),
      .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(to_v[2]),
      .result_code(res_v[2]), .cycle_count(cc_c), .wfi_count(wc_v[2]));

   assign cc_v[0] = cc_a;
   assign cc_v[1] = cc_b;
   assign cc_v[2] = {26'd0, cc_c};

   // Reference model state, one slot per configuration.
   bit          m_arm [3];
   bit          m_set [3];
   bit          m_fin [3];
   longint      m_n   [3];
   int          m_wc  [3];
   logic [31:0] m_cap [3];
   int          m_hold[3];
   bit          m_done[3], m_pass[3], m_fail[3], m_to[3];
   logic [31:0] m_res [3];

   function automatic longint p_timeout(input int i);
      return (i == 0) ? 64'd5000 : (i == 1) ? 64'd50 : 64'd0;
   endfunction
   function automatic int p_settle(input int i);
      return (i == 2) ? 0 : 8;
   endfunction
   function automatic longint p_cmax(input int i);
      return (i == 2) ? 64'd63 : 64'd4294967295;
   endfunction

   task automatic model_clear(input int i);
      m_arm[i] = 0; m_set[i] = 0; m_fin[i] = 0; m_n[i] = 0; m_wc[i] = 0;
      m_cap[i] = 0; m_hold[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_to[i] = 0; m_res[i] = 0;
   endtask

   task automatic model_finish(input int i, input logic [31:0] v);
      m_fin[i] = 1; m_done[i] = 1; m_res[i] = v;
      m_pass[i] = (v == 32'h0); m_fail[i] = (v != 32'h0);
   endtask

   // One clock edge of the exit protocol, applied to the inputs seen at that edge.
   task automatic model_step(input int i, input bit en, input bit w, input logic [31:0] a);
      bit hit_to;
      if (m_fin[i]) return;
      if (!m_arm[i]) begin
         if (en) m_arm[i] = 1;
         return;
      end
      hit_to = (p_timeout(i) != 0) && (m_n[i] == p_timeout(i) - 1);
      if (!en && !hit_to) begin
         model_clear(i);
         return;
      end
      if (m_n[i] < p_cmax(i)) m_n[i] = m_n[i] + 1;
      if (w && m_wc[i] < 65535) m_wc[i] = m_wc[i] + 1;
      if (hit_to) begin
         m_fin[i] = 1; m_done[i] = 1; m_fail[i] = 1; m_to[i] = 1; m_res[i] = 32'hFFFF_FFFF;
      end else if (!m_set[i]) begin
         if (w) begin
            if (p_settle(i) == 0) model_finish(i, a);
            else begin m_set[i] = 1; m_cap[i] = a; m_hold[i] = 0; end
         end
      end else if (a != m_cap[i]) begin
         m_cap[i] = a; m_hold[i] = 0;
      end else begin
         m_hold[i] = m_hold[i] + 1;
         if (m_hold[i] == p_settle(i)) model_finish(i, m_cap[i]);
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s/%0d.done", tag, i),    64'(done_v[i]), 64'(m_done[i]));
         chk($sformatf("%s/%0d.pass", tag, i),    64'(pass_v[i]), 64'(m_pass[i]));
         chk($sformatf("%s/%0d.fail", tag, i),    64'(fail_v[i]), 64'(m_fail[i]));
         chk($sformatf("%s/%0d.timeout", tag, i), 64'(to_v[i]),   64'(m_to[i]));
         chk($sformatf("%s/%0d.result", tag, i),  64'(res_v[i]),  64'(m_res[i]));
         chk($sformatf("%s/%0d.cycles", tag, i),  64'(cc_v[i]),   64'(m_n[i]));
         chk($sformatf("%s/%0d.wfis", tag, i),    64'(wc_v[i]),   64'(m_wc[i]));
      end
   endtask

   task automatic cyc(input bit en, input bit w, input logic [31:0] a);
      enable = en; wfi = w; a0 = a;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i, en, w, a);
      #1;
      check_all("cyc");
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; wfi = 1'b0; a0 = 32'd0;
      for (int i = 0; i < 3; i++) model_clear(i);
      @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] av;
      int          len;

      // Pass after settle: wfi at RUN cycle 100 with a0=0 held.
      do_reset();
      cyc(1, 0, 32'h1234);
      for (int k = 0; k < 100; k++) cyc(1, 0, $urandom);
      chk("a.cycles_at_100", 64'(cc_v[0]), 64'd100);
      chk("b.notimeout_to", 64'(to_v[1]), 64'd1);
      chk("b.notimeout_res", 64'(res_v[1]), 64'hFFFF_FFFF);
      chk("c.cycles_sat", 64'(cc_v[2]), 64'd63);
      cyc(1, 1, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         cyc(1, 0, 32'd0);
         chk($sformatf("a.latency_k%0d", k), 64'(done_v[0]), 64'(k >= 8));
      end
      chk("a.pass", 64'(pass_v[0]), 64'd1);
      chk("a.fail", 64'(fail_v[0]), 64'd0);
      chk("a.wfi_count", 64'(wc_v[0]), 64'd1);

      // Nonzero result fails.
      do_reset();
      for (int k = 0; k < 5; k++) cyc(1, 0, $urandom);
      cyc(1, 1, 32'd3);
      for (int k = 0; k < 10; k++) cyc(1, 0, 32'd3);
      chk("a.fail3", 64'(fail_v[0]), 64'd1);
      chk("a.pass3", 64'(pass_v[0]), 64'd0);
      chk("a.res3", 64'(res_v[0]), 64'd3);
      chk("a.to3", 64'(to_v[0]), 64'd0);

      // a0 changes during settle: capture restarts on the new value.
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 0, $urandom);
      cyc(1, 1, 32'd5);
      cyc(1, 0, 32'd5);
      cyc(1, 0, 32'd5);
      for (int k = 0; k < 12; k++) cyc(1, 0, 32'd7);
      chk("a.res7", 64'(res_v[0]), 64'd7);
      chk("a.fail7", 64'(fail_v[0]), 64'd1);

      // Timeout wins over a wfi at count 49; C concludes immediately on the same wfi.
      do_reset();
      cyc(1, 0, 32'd1);
      for (int k = 0; k < 49; k++) cyc(1, 0, $urandom_range(1, 9));
      chk("b.count49", 64'(cc_v[1]), 64'd49);
      cyc(1, 1, 32'd0);
      chk("b.to_wins", 64'(to_v[1]), 64'd1);
      chk("b.to_pass", 64'(pass_v[1]), 64'd0);
      chk("b.to_res", 64'(res_v[1]), 64'hFFFF_FFFF);
      chk("c.pass_now", 64'(pass_v[2]), 64'd1);
      cyc(1, 1, 32'd9);
      cyc(0, 0, 32'd5);
      cyc(0, 1, 32'd6);
      chk("c.frozen_res", 64'(res_v[2]), 64'd0);
      chk("c.frozen_wfis", 64'(wc_v[2]), 64'd1);

      // Abort by dropping enable, then restart from zero.
      do_reset();
      cyc(1, 0, 32'd2);
      for (int k = 0; k < 20; k++) cyc(1, 0, 32'd2);
      cyc(0, 0, 32'd2);
      chk("a.abort_cycles", 64'(cc_v[0]), 64'd0);
      cyc(1, 0, 32'd2);
      for (int k = 0; k < 3; k++) cyc(1, 0, 32'd2);
      chk("a.restart_cycles", 64'(cc_v[0]), 64'd3);

      // Asynchronous reset inside SETTLE.
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 0, 32'd4);
      cyc(1, 1, 32'h11);
      for (int k = 0; k < 3; k++) cyc(1, 0, 32'h11);
      reset = 1'b1;
      #2;
      for (int i = 0; i < 3; i++) model_clear(i);
      check_all("async");
      chk("a.async_cycles", 64'(cc_v[0]), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Randomized sessions.
      for (int t = 0; t < 25; t++) begin
         do_reset();
         len = $urandom_range(20, 160);
         av  = $urandom_range(0, 2);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 5) == 0) begin
               case ($urandom_range(0, 3))
                  0:       av = 32'd0;
                  1:       av = 32'd1;
                  2:       av = $urandom;
                  default: av = 32'd2;
               endcase
            end
            cyc(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, ($urandom_range(0, 19) == 0), av);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
